// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encodings,
// parity mode codes, oversampling tick constants and the parity check.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  localparam int OVERSAMPLE = 16;
  localparam int MID_START  = 7;

  // Tick counter compare values, sized to the 6-bit tick counter.
  localparam logic [5:0] TICK_MID   = 6'(MID_START);
  localparam logic [5:0] TICK_LAST  = 6'(OVERSAMPLE - 1);
  localparam logic [5:0] TICK_LAST2 = 6'(2 * OVERSAMPLE - 1);
  localparam logic [5:0] TICK_MAX   = 6'h3F;

  // Error when the data bits plus the received parity bit do not carry the
  // parity the mode asks for (same convention as the transmitter).
  function automatic logic par_error(input logic [1:0] mode,
                                     input logic [7:0] data,
                                     input logic       pbit);
    case (mode)
      PAR_ODD:  par_error = ~(^data ^ pbit);
      PAR_EVEN: par_error = ^data ^ pbit;
      default:  par_error = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to the
// line's idle-high value so a reset never looks like a start bit.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Double-register the asynchronous input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver with run-time frame format (7/8 data bits,
// none/odd/even parity, 1/2 stop bits). Format is latched at the start bit.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | line idle, waiting for synchronized rx low
// ST_START  | counting to mid start bit, rejecting glitches
// ST_DATA   | sampling data bits at mid bit, LSB first
// ST_PARITY | sampling parity bit (skipped at once when parity is off)
// ST_STOP   | sampling stop bit(s), then publishing the frame
module uart_rx
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_tick,
  input  logic       rx,
  input  logic [3:0] data_bits,
  input  logic [5:0] stop_bits,
  input  logic [1:0] parity_bits,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       parity_err,
  output logic       frame_err
);

  logic       w_rx_s;

  state_t     r_state,     w_state_nx;
  logic [5:0] r_s,         w_s_nx;
  logic [2:0] r_n,         w_n_nx;
  logic [7:0] r_sh,        w_sh_nx;
  logic       r_seven,     w_seven_nx;
  logic [5:0] r_sbits,     w_sbits_nx;
  logic [1:0] r_par,       w_par_nx;
  logic       r_pbit,      w_pbit_nx;
  logic       r_ferr_pend, w_ferr_pend_nx;
  logic [7:0] r_dout,      w_dout_nx;
  logic       r_done,      w_done_nx;
  logic       r_perr,      w_perr_nx;
  logic       r_ferr,      w_ferr_nx;

  logic [7:0] w_data;
  logic [2:0] w_n_last;
  logic [1:0] w_par_in;
  logic       w_tick_last;
  logic       w_stop_low;
  logic       w_ferr_now;
  logic       w_stop_end;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (rx),
    .o_q     (w_rx_s)
  );

  // In 7-bit mode the data sits in sh[7:1]; one more right shift aligns it.
  assign w_data      = r_seven ? {1'b0, r_sh[7:1]} : r_sh;
  assign w_n_last    = r_seven ? 3'd6 : 3'd7;
  assign w_par_in    = ((parity_bits == PAR_ODD) || (parity_bits == PAR_EVEN))
                       ? parity_bits : PAR_NONE;
  assign w_tick_last = (r_s == TICK_LAST);
  assign w_stop_low  = ((r_s == TICK_LAST) ||
                        ((r_s == TICK_LAST2) && (r_sbits == 6'd32))) && !w_rx_s;
  assign w_ferr_now  = r_ferr_pend | w_stop_low;
  // The all-ones guard keeps s from wrapping if an odd stop length was latched.
  assign w_stop_end  = (r_s == (r_sbits - 6'd1)) || (r_s == TICK_MAX);

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_s         <= '0;
      r_n         <= '0;
      r_sh        <= '0;
      r_seven     <= 1'b0;
      r_sbits     <= '0;
      r_par       <= PAR_NONE;
      r_pbit      <= 1'b0;
      r_ferr_pend <= 1'b0;
      r_dout      <= '0;
      r_done      <= 1'b0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_s         <= w_s_nx;
      r_n         <= w_n_nx;
      r_sh        <= w_sh_nx;
      r_seven     <= w_seven_nx;
      r_sbits     <= w_sbits_nx;
      r_par       <= w_par_nx;
      r_pbit      <= w_pbit_nx;
      r_ferr_pend <= w_ferr_pend_nx;
      r_dout      <= w_dout_nx;
      r_done      <= w_done_nx;
      r_perr      <= w_perr_nx;
      r_ferr      <= w_ferr_nx;
    end
  end

  // Next-state and datapath updates; everything holds unless a state acts.
  always_comb begin
    w_state_nx     = r_state;
    w_s_nx         = r_s;
    w_n_nx         = r_n;
    w_sh_nx        = r_sh;
    w_seven_nx     = r_seven;
    w_sbits_nx     = r_sbits;
    w_par_nx       = r_par;
    w_pbit_nx      = r_pbit;
    w_ferr_pend_nx = r_ferr_pend;
    w_dout_nx      = r_dout;
    w_done_nx      = 1'b0;
    w_perr_nx      = r_perr;
    w_ferr_nx      = r_ferr;

    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_s_nx         = '0;
          w_seven_nx     = (data_bits == 4'd7);
          w_sbits_nx     = stop_bits;
          w_par_nx       = w_par_in;
          w_ferr_pend_nx = 1'b0;
          w_state_nx     = ST_START;
        end
      end

      ST_START: begin
        if (s_tick) begin
          if (r_s == TICK_MID) begin
            if (!w_rx_s) begin
              w_s_nx     = '0;
              w_n_nx     = '0;
              w_state_nx = ST_DATA;
            end else begin
              w_state_nx = ST_IDLE;
            end
          end else begin
            w_s_nx = r_s + 6'd1;
          end
        end
      end

      ST_DATA: begin
        if (s_tick) begin
          if (w_tick_last) begin
            w_sh_nx = {w_rx_s, r_sh[7:1]};
            w_s_nx  = '0;
            w_n_nx  = r_n + 3'd1;
            if (r_n == w_n_last) begin
              w_state_nx = ST_PARITY;
            end
          end else begin
            w_s_nx = r_s + 6'd1;
          end
        end
      end

      ST_PARITY: begin
        if (r_par == PAR_NONE) begin
          w_s_nx     = '0;
          w_state_nx = ST_STOP;
        end else if (s_tick) begin
          if (w_tick_last) begin
            w_pbit_nx  = w_rx_s;
            w_s_nx     = '0;
            w_state_nx = ST_STOP;
          end else begin
            w_s_nx = r_s + 6'd1;
          end
        end
      end

      ST_STOP: begin
        if (s_tick) begin
          w_ferr_pend_nx = w_ferr_now;
          if (w_stop_end) begin
            w_dout_nx  = w_data;
            w_perr_nx  = par_error(r_par, w_data, r_pbit);
            w_ferr_nx  = w_ferr_now;
            w_done_nx  = 1'b1;
            w_s_nx     = '0;
            w_state_nx = ST_IDLE;
          end else begin
            w_s_nx = r_s + 6'd1;
          end
        end
      end

      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  assign dout         = r_dout;
  assign rx_done_tick = r_done;
  assign parity_err   = r_perr;
  assign frame_err    = r_ferr;

endmodule
